alu_functional_unit: RTL and testbench
======================================

// Module: alu_functional_unit
// PURPOSE
//  Pipelined integer functional unit directly downstream of the reservation station.
//  - Consumes one ready instruction per cycle: ROB index, opcode, immediate and two resolved operands.
//  - Computes a 16-bit result in a 2-stage pipeline.
//  - Queues results in a small FIFO and broadcasts them on one common-data-bus (CDB) slot
//    using a req/grant handshake.
// PARAMETERS
//  FIFO_DEPTH  4   result-queue entries (power of 2, >=2)
//  DATA_W      16  operand/result width
//  IDX_W       4   ROB index width
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst             in   1       synchronous reset, active-high
//  in_valid        in   1       instruction presented this cycle (from RS out_valid)
//  in_instr_index  in   IDX_W   ROB index of instruction
//  in_opcode       in   4       operation select
//  in_i            in   8       immediate
//  in_val1         in   DATA_W  resolved operand 1
//  in_val2         in   DATA_W  resolved operand 2
//  cdb_grant       in   1       CDB arbiter accepts head result this cycle
//  cdb_req         out  1       head result valid, requesting CDB slot
//  cdb_rob_index   out  IDX_W   ROB index of head result
//  cdb_result      out  DATA_W  head result value
//  busy            out  1       upstream must stop issuing (occupancy high-water)
//  overflow        out  1       sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: S1/S2 valid=0, FIFO empty (rd/wr ptr=0, count=0), overflow=0.
//   Outputs after reset: cdb_req=0, busy=0, overflow=0; cdb_rob_index/cdb_result=0.
//  Pipeline never stalls. An input seen at edge N is handled as follows:
//   - captured into S1 at edge N;
//   - result computed and registered into S2 at edge N+1;
//   - pushed into the FIFO at edge N+2;
//   - cdb_req visible in the cycle after edge N+2, if the FIFO was empty.
//  Opcodes (wrap-around, mod 2^16):
//   0 ADD v1+v2;  1 SUB v1-v2;  2 AND;  3 OR;  4 XOR
//   5 SHL v1<<v2[3:0];  6 SHR logical v1>>v2[3:0];  7 MOVI {8'h00,i}
//   8 ADDI v1+sign_ext(i);  9 SLT (signed v1<signed v2) ? 1 : 0
//   10-15 result 0, still broadcast so the ROB entry retires.
//  FIFO/CDB handshake:
//   - cdb_req = (count!=0); cdb_rob_index/cdb_result = head entry, combinational from storage.
//   - Pop on cdb_req & cdb_grant. cdb_grant while cdb_req=0 is ignored.
//   - Head data holds stable while cdb_req=1 and no grant.
//   - Push on S2 valid. When full, push+pop in the same cycle is legal: count unchanged.
//   - Full, S2 valid, no pop: result dropped, overflow<=1 until reset.
//   - Pointers wrap modulo FIFO_DEPTH; results leave in issue order.
//  busy = (count + S1.valid + S2.valid) >= FIFO_DEPTH-1, combinational.
//   - Gives one cycle of margin for the registered RS output.
//   - No overflow if upstream stops issuing the cycle after busy rises.
//  Reset mid-operation: in-flight S1/S2 and all queued results are discarded;
//   cdb_req=0 the cycle after the reset edge.
// TESTING
//  1 ADD 3+4, idx 5, grant held 1
//     -> cdb_req, idx 5, result 7 two edges after issue; popped next edge.
//  2 Back-to-back: SUB 2-5, SHL 1<<15, ADDI 10+(i=8'hFE), SLT -1<1, MOVI i=8'hAB
//     -> in-order results FFFD, 8000, 0008, 0001, 00AB.
//  3 cdb_grant=0, issue 6 instrs ignoring busy
//     -> busy rises at occupancy 3; 4 queued results held stable; overflow=1; 4th-issued retained.
//  4 FIFO full with S2 valid and grant=1 the same cycle
//     -> head popped, new result enqueued, count stays 4, overflow stays 0.
//  5 rst asserted with 2 queued + 2 in flight
//     -> next cycle cdb_req=0, busy=0, overflow=0; new ADD produces a correct result.
//  6 Opcode 12 with v1=v2=FFFF
//     -> result 0000 broadcast with the correct index.

Source files
------------

// File: rtl/alu_functional_unit_if.sv
// Reservation-station-to-functional-unit issue bus plus the CDB request/grant slot.
interface alu_functional_unit_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic [IDX_W-1:0]  in_instr_index;
  logic [3:0]        in_opcode;
  logic [7:0]        in_i;
  logic [DATA_W-1:0] in_val1;
  logic [DATA_W-1:0] in_val2;
  logic              cdb_grant;
  logic              cdb_req;
  logic [IDX_W-1:0]  cdb_rob_index;
  logic [DATA_W-1:0] cdb_result;
  logic              busy;
  logic              overflow;

  modport master (
    output in_valid, in_instr_index, in_opcode, in_i, in_val1, in_val2, cdb_grant,
    input  cdb_req, cdb_rob_index, cdb_result, busy, overflow
  );

  modport slave (
    input  in_valid, in_instr_index, in_opcode, in_i, in_val1, in_val2, cdb_grant,
    output cdb_req, cdb_rob_index, cdb_result, busy, overflow
  );
endinterface

// File: rtl/alu_functional_unit.sv
// Two-stage integer ALU feeding a small result queue that drains onto one CDB slot.
// The pipeline never stalls; a result arriving at a full queue with no pop is dropped.
module alu_functional_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_functional_unit_if.slave fu_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR  = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MOVI = 4'd7,
    OP_ADDI = 4'd8, OP_SLT = 4'd9
  } opcode_e;

  // Stage 1: registered issue
  logic              s1_valid_q;
  logic [IDX_W-1:0]  s1_idx_q;
  opcode_e           s1_op_q;
  logic [7:0]        s1_imm_q;
  logic [DATA_W-1:0] s1_v1_q, s1_v2_q;

  // Stage 2: registered result
  logic              s2_valid_q;
  logic [IDX_W-1:0]  s2_idx_q;
  logic [DATA_W-1:0] s2_res_q;
  logic [DATA_W-1:0] result_d;

  // Result queue
  logic [IDX_W-1:0]  mem_idx_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_res_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q;
  logic              full, pop, push;
  logic [OCC_W-1:0]  occupancy;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= fu_if.in_valid;
      s2_valid_q <= s1_valid_q;
    end
    s1_idx_q <= fu_if.in_instr_index;
    s1_op_q  <= opcode_e'(fu_if.in_opcode);
    s1_imm_q <= fu_if.in_i;
    s1_v1_q  <= fu_if.in_val1;
    s1_v2_q  <= fu_if.in_val2;
    s2_idx_q <= s1_idx_q;
    s2_res_q <= result_d;
  end

  always_comb begin
    result_d = '0;
    case (s1_op_q)
      OP_ADD:  result_d = s1_v1_q + s1_v2_q;
      OP_SUB:  result_d = s1_v1_q - s1_v2_q;
      OP_AND:  result_d = s1_v1_q & s1_v2_q;
      OP_OR:   result_d = s1_v1_q | s1_v2_q;
      OP_XOR:  result_d = s1_v1_q ^ s1_v2_q;
      OP_SHL:  result_d = s1_v1_q << s1_v2_q[3:0];
      OP_SHR:  result_d = s1_v1_q >> s1_v2_q[3:0];
      OP_MOVI: result_d = {{(DATA_W-8){1'b0}}, s1_imm_q};
      OP_ADDI: result_d = s1_v1_q + {{(DATA_W-8){s1_imm_q[7]}}, s1_imm_q};
      OP_SLT:  result_d = ($signed(s1_v1_q) < $signed(s1_v2_q)) ? DATA_W'(1) : '0;
      default: result_d = '0;
    endcase
  end

  // A full queue can still accept when the head leaves in the same cycle.
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && fu_if.cdb_grant;
  assign push      = s2_valid_q && (!full || pop);
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign occupancy = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (s2_valid_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx_q[wr_ptr_q] <= s2_idx_q;
      mem_res_q[wr_ptr_q] <= s2_res_q;
    end
  end

  // Head fields read as zero while the queue is empty so stale entries never leak out.
  assign fu_if.cdb_req       = (count_q != '0);
  assign fu_if.cdb_rob_index = fu_if.cdb_req ? mem_idx_q[rd_ptr_q] : '0;
  assign fu_if.cdb_result    = fu_if.cdb_req ? mem_res_q[rd_ptr_q] : '0;
  assign fu_if.busy          = (occupancy >= OCC_W'(FIFO_DEPTH - 1));
  assign fu_if.overflow      = overflow_q;
endmodule

// File: tb/tb_alu_functional_unit.sv
// Directed, table-driven check of the pipelined ALU functional unit and its CDB queue.
module tb_alu_functional_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_functional_unit_if bus ();

  alu_functional_unit dut (
    .clk   (clk),
    .rst   (rst),
    .fu_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  logic [3:0]  exp_idx_q [$];
  logic [15:0] exp_res_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] idx, input logic [3:0] op, input logic [7:0] imm,
                       input logic [15:0] v1, input logic [15:0] v2);
    bus.in_valid       = 1'b1;
    bus.in_instr_index = idx;
    bus.in_opcode      = op;
    bus.in_i           = imm;
    bus.in_val1        = v1;
    bus.in_val2        = v2;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    bus.cdb_grant = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_expect(input string name, input int budget);
    int cyc = 0;
    bus.cdb_grant = 1'b1;
    while (exp_idx_q.size() != 0 && cyc < budget) begin
      if (bus.cdb_req) begin
        $display("%s pop idx=%0d res=%04h", name, bus.cdb_rob_index, bus.cdb_result);
        check({name, "_idx"}, 32'(bus.cdb_rob_index), 32'(exp_idx_q.pop_front()));
        check({name, "_res"}, 32'(bus.cdb_result), 32'(exp_res_q.pop_front()));
      end
      tick();
      cyc++;
    end
    if (exp_idx_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d results short expected 0", name, exp_idx_q.size());
      exp_idx_q.delete();
      exp_res_q.delete();
    end
    check({name, "_empty_req"}, 32'(bus.cdb_req), 32'd0);
    bus.cdb_grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    vecs[0]  = '{4'd1,  4'd0,  8'h00, 16'h0003, 16'h0004, 16'h0007};
    vecs[1]  = '{4'd2,  4'd1,  8'h00, 16'h0002, 16'h0005, 16'hFFFD};
    vecs[2]  = '{4'd3,  4'd5,  8'h00, 16'h0001, 16'h000F, 16'h8000};
    vecs[3]  = '{4'd4,  4'd8,  8'hFE, 16'h000A, 16'h0000, 16'h0008};
    vecs[4]  = '{4'd5,  4'd9,  8'h00, 16'hFFFF, 16'h0001, 16'h0001};
    vecs[5]  = '{4'd6,  4'd7,  8'hAB, 16'h1234, 16'h5678, 16'h00AB};
    vecs[6]  = '{4'd7,  4'd2,  8'h00, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[7]  = '{4'd8,  4'd3,  8'h00, 16'h00F0, 16'h0F00, 16'h0FF0};
    vecs[8]  = '{4'd9,  4'd4,  8'h00, 16'hFFFF, 16'h00FF, 16'hFF00};
    vecs[9]  = '{4'd10, 4'd6,  8'h00, 16'h8000, 16'h0014, 16'h0800};
    vecs[10] = '{4'd11, 4'd0,  8'h00, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[11] = '{4'd12, 4'd9,  8'h00, 16'h0001, 16'hFFFF, 16'h0000};
    vecs[12] = '{4'd13, 4'd12, 8'h00, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[13] = '{4'd14, 4'd8,  8'h7F, 16'h0005, 16'h0000, 16'h0084};
    vecs[14] = '{4'd15, 4'd5,  8'h00, 16'h1234, 16'h0010, 16'h1234};

    bus.in_valid = 1'b0; bus.in_instr_index = '0; bus.in_opcode = '0; bus.in_i = '0;
    bus.in_val1 = '0; bus.in_val2 = '0; bus.cdb_grant = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_req", 32'(bus.cdb_req), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_idx", 32'(bus.cdb_rob_index), 32'd0);
    check("rst_res", 32'(bus.cdb_result), 32'd0);

    // Single ADD latency, grant held high
    bus.cdb_grant = 1'b1;
    drive(4'd5, 4'd0, 8'h00, 16'd3, 16'd4);
    tick();
    idle();
    check("lat_e0_req", 32'(bus.cdb_req), 32'd0);
    tick();
    check("lat_e1_req", 32'(bus.cdb_req), 32'd0);
    tick();
    $display("lat pop idx=%0d res=%04h", bus.cdb_rob_index, bus.cdb_result);
    check("lat_e2_req", 32'(bus.cdb_req), 32'd1);
    check("lat_e2_idx", 32'(bus.cdb_rob_index), 32'd5);
    check("lat_e2_res", 32'(bus.cdb_result), 32'h7);
    tick();
    check("lat_e3_req", 32'(bus.cdb_req), 32'd0);

    // Back-to-back vector table, grant held high
    do_reset();
    bus.cdb_grant = 1'b1;
    k = 0;
    for (int c = 0; c < NVEC + 6; c++) begin
      if (c < NVEC) drive(vecs[c].idx, vecs[c].op, vecs[c].imm, vecs[c].v1, vecs[c].v2);
      else idle();
      tick();
      if (bus.cdb_req && k < NVEC) begin
        $display("vec%0d pop idx=%0d res=%04h", k, bus.cdb_rob_index, bus.cdb_result);
        check($sformatf("vec%0d_idx", k), 32'(bus.cdb_rob_index), 32'(vecs[k].idx));
        check($sformatf("vec%0d_res", k), 32'(bus.cdb_result), 32'(vecs[k].exp));
        k++;
      end
    end
    check("vec_count", 32'(k), 32'(NVEC));
    bus.cdb_grant = 1'b0;

    // Overflow with grant low, six issues ignoring busy
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'(i), 4'd0, 8'h00, 16'(i), 16'd100);
      tick();
      if (i == 1) check("ovf_busy_e1", 32'(bus.busy), 32'd0);
      if (i == 2) check("ovf_busy_e2", 32'(bus.busy), 32'd1);
      if (i == 5) check("ovf_e5_flag", 32'(bus.overflow), 32'd0);
    end
    idle();
    tick();
    check("ovf_e6_flag", 32'(bus.overflow), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ovf_hold_req", 32'(bus.cdb_req), 32'd1);
      check("ovf_hold_idx", 32'(bus.cdb_rob_index), 32'd0);
      check("ovf_hold_res", 32'(bus.cdb_result), 32'd100);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      exp_idx_q.push_back(4'(i));
      exp_res_q.push_back(16'(100 + i));
    end
    drain_expect("ovf", 20);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset with 2 queued + 2 in flight (overflow still set from above)
    for (int i = 0; i < 4; i++) begin
      drive(4'(i), 4'd0, 8'h00, 16'(i), 16'd50);
      tick();
    end
    idle();
    check("mid_pre_req", 32'(bus.cdb_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_req", 32'(bus.cdb_req), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_ovf", 32'(bus.overflow), 32'd0);
    tick(); tick(); tick();
    check("mid_flush_req", 32'(bus.cdb_req), 32'd0);
    bus.cdb_grant = 1'b1;
    drive(4'd3, 4'd0, 8'h00, 16'd20, 16'd22);
    tick();
    idle();
    tick(); tick();
    $display("mid pop idx=%0d res=%04h", bus.cdb_rob_index, bus.cdb_result);
    check("mid_new_req", 32'(bus.cdb_req), 32'd1);
    check("mid_new_idx", 32'(bus.cdb_rob_index), 32'd3);
    check("mid_new_res", 32'(bus.cdb_result), 32'd42);
    tick();
    check("mid_new_pop", 32'(bus.cdb_req), 32'd0);
    bus.cdb_grant = 1'b0;

    // Full queue, S2 valid and grant in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'(8 + i), 4'd0, 8'h00, 16'(i), 16'd200);
      tick();
    end
    idle();
    tick();
    check("full_busy", 32'(bus.busy), 32'd1);
    check("full_head_idx", 32'(bus.cdb_rob_index), 32'd8);
    bus.cdb_grant = 1'b1;
    tick();
    bus.cdb_grant = 1'b0;
    check("full_ovf", 32'(bus.overflow), 32'd0);
    check("full_head2_idx", 32'(bus.cdb_rob_index), 32'd9);
    check("full_head2_res", 32'(bus.cdb_result), 32'd201);
    tick();
    check("full_ovf_later", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      exp_idx_q.push_back(4'(8 + i));
      exp_res_q.push_back(16'(200 + i));
    end
    drain_expect("full", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
